// File: rtl/mips_pkg.sv
// Shared definitions for the EXE-stage multiply/divide controller:
// FSM state encoding, multiply/divide op codes and the EXE command decode.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        EXE_NONE  = 3'd0,
        EXE_MULT  = 3'd1,
        EXE_MULTU = 3'd2,
        EXE_DIV   = 3'd3,
        EXE_DIVU  = 3'd4
    } exe_cmd_t;

    typedef struct packed {
        logic start;
        logic op;
        logic sgn;
    } md_ctrl_t;

    // Map an EXE command to the controller's start/op/sgn inputs.
    function automatic md_ctrl_t decode_exe_cmd(input exe_cmd_t cmd);
        md_ctrl_t ctrl;
        ctrl = '{start: 1'b0, op: OP_MUL, sgn: 1'b0};
        case (cmd)
            EXE_MULT:  ctrl = '{start: 1'b1, op: OP_MUL, sgn: 1'b1};
            EXE_MULTU: ctrl = '{start: 1'b1, op: OP_MUL, sgn: 1'b0};
            EXE_DIV:   ctrl = '{start: 1'b1, op: OP_DIV, sgn: 1'b1};
            EXE_DIVU:  ctrl = '{start: 1'b1, op: OP_DIV, sgn: 1'b0};
            default:   ctrl = '{start: 1'b0, op: OP_MUL, sgn: 1'b0};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/muldiv_exe_ctrl_if.sv
// EXE-stage <-> multiply/divide controller bus. The pipeline side is the
// master (request, operands, flush); the controller is the slave.
interface muldiv_exe_ctrl_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op;
    logic             sgn;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic             flush;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, sgn, val1, val2, flush,
        input  stall, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, sgn, val1, val2, flush,
        output stall, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply and restoring divide on
// unsigned magnitudes. Holds the 2W accumulator (product, or
// remainder:quotient) and the addend/divisor operand.
module muldiv_iter_core
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic               op,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   addend_reg, addend_next;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   diff;
    logic               fits;

    // Next accumulator: load operands, or perform one multiply/divide iteration.
    always_comb begin
        acc_next    = acc_reg;
        addend_next = addend_reg;
        // Multiply: the carry out of the upper-half add is shifted back in.
        sum         = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                      (acc_reg[0] ? {1'b0, addend_reg} : '0);
        // Divide: remainder shifted left with the next dividend bit; it can
        // transiently need W+1 bits before the trial subtract.
        rem_shift   = acc_reg[2*WIDTH-1:WIDTH-1];
        fits        = (rem_shift >= {1'b0, addend_reg});
        // Only used when the subtract fits, so the result is below 2^W.
        diff        = rem_shift[WIDTH-1:0] - addend_reg;
        if (load) begin
            // Multiply keeps the multiplier in the low half and adds the
            // multiplicand; divide keeps the dividend and subtracts the divisor.
            if (op == OP_DIV) begin
                acc_next    = {{WIDTH{1'b0}}, opa};
                addend_next = opb;
            end else begin
                acc_next    = {{WIDTH{1'b0}}, opb};
                addend_next = opa;
            end
        end else if (step) begin
            if (op == OP_DIV) begin
                if (fits) begin
                    acc_next = {diff, acc_reg[WIDTH-2:0], 1'b1};
                end else begin
                    acc_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_next = {sum, acc_reg[WIDTH-1:1]};
            end
        end
    end

    // Pure datapath state: always written by load before it is meaningful.
    always_ff @(posedge clk) begin
        acc_reg    <= acc_next;
        addend_reg <= addend_next;
    end

    assign acc = acc_reg;

endmodule

// File: rtl/muldiv_exe_ctrl.sv
// Iterative multiply/divide controller beside the EXE ALU. Accepts one
// request, stalls the pipeline for WIDTH iterations plus a sign-fixup
// cycle, then commits HI/LO and pulses done. flush aborts without commit.
module muldiv_exe_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    muldiv_exe_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t          state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               op_reg;
    logic               neg_quo_reg;
    logic               neg_rem_reg;
    logic               div_zero_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic [WIDTH-1:0]   hi_next, lo_next;

    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               accept;
    logic               core_step;
    logic               core_op;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes and the accept/step strobes for the datapath.
    always_comb begin
        neg_a     = bus.sgn & bus.val1[WIDTH-1];
        neg_b     = bus.sgn & bus.val2[WIDTH-1];
        mag_a     = neg_a ? -bus.val1 : bus.val1;
        mag_b     = neg_b ? -bus.val2 : bus.val2;
        accept    = (state_reg == IDLE) && bus.start && !bus.flush && !rst;
        core_step = (state_reg == RUN) && !bus.flush;
        // The live op is only needed on the load cycle; afterwards the latched one.
        core_op   = (state_reg == IDLE) ? bus.op : op_reg;
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .load (accept),
        .step (core_step),
        .op   (core_op),
        .opa  (mag_a),
        .opb  (mag_b),
        .acc  (acc)
    );

    // Sign fixup of the unsigned result into the HI/LO values committed in FIX.
    always_comb begin
        prod    = neg_quo_reg ? -acc : acc;
        hi_next = prod[2*WIDTH-1:WIDTH];
        lo_next = prod[WIDTH-1:0];
        if (op_reg == OP_DIV) begin
            // With a zero divisor every trial subtract succeeds, so the
            // remainder is the dividend magnitude; re-signing it restores
            // the raw dividend. Only the quotient needs forcing.
            hi_next = neg_rem_reg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            if (div_zero_reg) begin
                lo_next = '1;
            end else begin
                lo_next = neg_quo_reg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    // Controller FSM: IDLE -> RUN (WIDTH cycles) -> FIX -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            op_reg       <= OP_MUL;
            neg_quo_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            if (bus.flush) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start) begin
                            state_reg    <= RUN;
                            cnt_reg      <= '0;
                            op_reg       <= bus.op;
                            neg_quo_reg  <= neg_a ^ neg_b;
                            neg_rem_reg  <= neg_a;
                            div_zero_reg <= (bus.op == OP_DIV) && (bus.val2 == '0);
                        end
                    end
                    RUN: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                            state_reg <= FIX;
                        end
                    end
                    FIX: begin
                        hi_reg    <= hi_next;
                        lo_reg    <= lo_next;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                    DONE: begin
                        // The finished instruction is still in EXE: ignore start.
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.stall    = accept ||
                          (((state_reg == RUN) || (state_reg == FIX)) && !bus.flush && !rst);
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_muldiv_exe_ctrl.sv
// Self-checking bench for muldiv_exe_ctrl: directed vector table, random
// operations against a 64-bit arithmetic reference, and hand-written
// flush / back-to-back / reset-abort sequences.
module tb_muldiv_exe_ctrl;
    import mips_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk;
    logic rst;
    muldiv_exe_ctrl_if #(.WIDTH(W)) bus ();

    muldiv_exe_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        exe_cmd_t    cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (inputs are driven here).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic with the architectural corner rules.
    function automatic void model(input logic op, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic ed);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        ed = 1'b0;
        if (op == OP_MUL) begin
            if (sgn) begin
                p = longint'($signed(a)) * longint'($signed(b));
                {eh, el} = p;
            end else begin
                up = {32'b0, a} * {32'b0, b};
                {eh, el} = up;
            end
        end else if (b == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = a;
            ed = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endfunction

    // Issue one instruction, hold start until done, then release it.
    // Entered and left just after a rising edge; the request cycle is cycle 0.
    task automatic run_op(input logic op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r_hi, output logic [31:0] r_lo,
                          output logic r_dz, output int lat,
                          output bit stall_ok, output bit hold_ok, output bit pulse_ok);
        logic [31:0] pre_hi, pre_lo;
        pre_hi   = bus.hi;
        pre_lo   = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.sgn   = sgn;
        bus.val1  = a;
        bus.val2  = b;
        lat      = -1;
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        pulse_ok = 1'b1;
        r_hi     = bus.hi;
        r_lo     = bus.lo;
        r_dz     = bus.div_zero;
        for (int c = 0; c < 60; c++) begin
            #3;
            if (bus.done) begin
                lat  = c;
                r_hi = bus.hi;
                r_lo = bus.lo;
                r_dz = bus.div_zero;
                if (bus.stall) stall_ok = 1'b0;
                break;
            end
            if (!bus.stall) stall_ok = 1'b0;
            if (bus.hi !== pre_hi || bus.lo !== pre_lo) hold_ok = 1'b0;
            next_cycle();
        end
        next_cycle();
        bus.start = 1'b0;
        #3;
        if (bus.done) pulse_ok = 1'b0;
        next_cycle();
    endtask

    task automatic do_check(input string name, input logic op, input logic sgn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input logic ed);
        logic [31:0] g_hi, g_lo;
        logic        g_dz;
        int          lat;
        bit          s_ok, h_ok, p_ok;
        run_op(op, sgn, a, b, g_hi, g_lo, g_dz, lat, s_ok, h_ok, p_ok);
        $display("%s op=%0d sgn=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d",
                 name, op, sgn, a, b, g_hi, g_lo, g_dz, lat);
        check({name, ".hi"}, 64'(g_hi), 64'(eh));
        check({name, ".lo"}, 64'(g_lo), 64'(el));
        check({name, ".div_zero"}, 64'(g_dz), 64'(ed));
        check({name, ".latency"}, 64'(lat), 64'(LAT));
        check({name, ".stall_window"}, 64'(s_ok), 64'(1));
        check({name, ".hilo_hold"}, 64'(h_ok), 64'(1));
        check({name, ".done_one_cycle"}, 64'(p_ok), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        md_ctrl_t    ctl;
        logic [31:0] eh, el;
        logic        ed;
        logic        r_op, r_sgn;
        logic [31:0] ra, rb;
        int          c1, c2, n_done;
        bit          ok;

        tbl[0] = '{EXE_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[1] = '{EXE_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[2] = '{EXE_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{EXE_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        tbl[4] = '{EXE_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[5] = '{EXE_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        tbl[6] = '{EXE_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[7] = '{EXE_MULTU, 32'd0,         32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[8] = '{EXE_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[9] = '{EXE_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.sgn   = 1'b0;
        bus.val1  = '0;
        bus.val2  = '0;
        bus.flush = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #3;
        check("reset.hi", 64'(bus.hi), 64'(0));
        check("reset.lo", 64'(bus.lo), 64'(0));
        check("reset.done", 64'(bus.done), 64'(0));
        check("reset.stall", 64'(bus.stall), 64'(0));
        check("reset.div_zero", 64'(bus.div_zero), 64'(0));
        next_cycle();

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            ctl = decode_exe_cmd(tbl[i].cmd);
            do_check($sformatf("vec%0d", i), ctl.op, ctl.sgn, tbl[i].a, tbl[i].b,
                     tbl[i].eh, tbl[i].el, tbl[i].ed);
        end

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            r_op  = 1'($urandom_range(0, 1));
            r_sgn = 1'($urandom_range(0, 1));
            ra    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = 32'($urandom);
            endcase
            model(r_op, r_sgn, ra, rb, eh, el, ed);
            do_check($sformatf("rnd%0d", i), r_op, r_sgn, ra, rb, eh, el, ed);
        end

        // Flush mid-divide: preload HI/LO = 1/2, abort at cycle 10.
        do_check("preload", OP_MUL, 1'b0, 32'h8000_0001, 32'd2, 32'd1, 32'd2, 1'b0);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.sgn   = 1'b0;
        bus.val1  = 32'd50;
        bus.val2  = 32'd7;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #3;
            if (!bus.stall || bus.done) ok = 1'b0;
            next_cycle();
        end
        check("flush.stall_before", 64'(ok), 64'(1));
        bus.flush = 1'b1;
        #3;
        check("flush.stall_same_cycle", 64'(bus.stall), 64'(0));
        next_cycle();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        n_done = 0;
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #3;
            if (bus.done) n_done++;
            if (bus.stall) ok = 1'b0;
            next_cycle();
        end
        $display("flush DIVU 50/7 at cycle 10 -> dones=%0d hi=%h lo=%h", n_done, bus.hi, bus.lo);
        check("flush.no_done", 64'(n_done), 64'(0));
        check("flush.stall_low_after", 64'(ok), 64'(1));
        check("flush.hi_kept", 64'(bus.hi), 64'(1));
        check("flush.lo_kept", 64'(bus.lo), 64'(2));
        do_check("after_flush", OP_DIV, 1'b0, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0);

        // Back-to-back: start held through DONE, next instruction right after.
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.sgn   = 1'b0;
        bus.val1  = 32'd6;
        bus.val2  = 32'd7;
        c1 = -1;
        c2 = -1;
        n_done = 0;
        for (int c = 0; c < 110; c++) begin
            #3;
            if (bus.done) begin
                n_done++;
                if (c1 < 0) begin
                    c1 = c;
                    check("b2b.first_hi", 64'(bus.hi), 64'(0));
                    check("b2b.first_lo", 64'(bus.lo), 64'(42));
                end else if (c2 < 0) begin
                    c2 = c;
                    check("b2b.second_hi", 64'(bus.hi), 64'(2));
                    check("b2b.second_lo", 64'(bus.lo), 64'(14));
                end
            end
            next_cycle();
            if (c1 >= 0 && c == c1) begin
                // Cycle after DONE: the next instruction is in EXE.
                bus.op   = OP_DIV;
                bus.val1 = 32'd100;
                bus.val2 = 32'd7;
            end
            if (c2 >= 0 && c == c2) bus.start = 1'b0;
        end
        $display("back-to-back MULTU 6*7, DIVU 100/7 -> first=%0d second=%0d dones=%0d", c1, c2, n_done);
        check("b2b.first_latency", 64'(c1), 64'(LAT));
        check("b2b.spacing", 64'(c2 - c1), 64'(LAT + 1));
        check("b2b.done_count", 64'(n_done), 64'(2));
        bus.start = 1'b0;
        next_cycle();

        // Reset in the middle of a MULT.
        do_check("preload2", OP_MUL, 1'b1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.sgn   = 1'b1;
        bus.val1  = 32'd5;
        bus.val2  = 32'hFFFF_FFFB;
        for (int c = 0; c < 20; c++) next_cycle();
        rst       = 1'b1;
        bus.start = 1'b0;
        next_cycle();
        rst = 1'b0;
        #3;
        check("rst_mid.hi", 64'(bus.hi), 64'(0));
        check("rst_mid.lo", 64'(bus.lo), 64'(0));
        check("rst_mid.stall", 64'(bus.stall), 64'(0));
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) n_done++;
            next_cycle();
            #3;
        end
        $display("reset at cycle 20 of MULT 5*-5 -> dones=%0d hi=%h lo=%h", n_done, bus.hi, bus.lo);
        check("rst_mid.no_done", 64'(n_done), 64'(0));
        next_cycle();
        do_check("after_rst", OP_MUL, 1'b1, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFE7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
